// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: Sysbus memory model that accepts 8-beat line writes and returns 8-beat line reads after a fixed latency
//
// Ports:
//   clk          single clock, all state changes on its rising edge
//   reset        asynchronous active-high reset (memory contents are kept)
//   bus_reqcyc   initiator presents an address beat (IDLE) or a write-data beat (WDATA)
//   bus_req      byte address in the address phase, write data in the data phase
//   bus_reqtag   [12] 1=read/0=write, [11:8] type (4'b0001 = memory), [7:0] initiator id
//   bus_reqack   one-cycle pulse accepting the current address or data beat
//   bus_respcyc  read beat valid
//   bus_resp     read data, held stable until accepted
//   bus_resptag  tag captured with the request being answered
//   bus_respack  initiator accepts the current read beat
module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [3:0] TYPE_MEMORY = 4'b0001;

    typedef enum logic [2:0] {IDLE, AACK, WDATA, WACK, RWAIT, RDATA, DROP} state_t;

    state_t                    state;
    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [AW-1:0]             line;
    logic [2:0]                beat;
    logic [CW-1:0]             cnt;
    logic [BUS_TAG_WIDTH-1:0]  tag;
    logic                      we;
    logic [AW-1:0]             wr_idx;
    logic [AW-1:0]             rd_idx;

    // Word index arithmetic is AW bits wide, so every access wraps modulo MEM_WORDS.
    assign we     = (state == WDATA) && bus_reqcyc;
    assign wr_idx = line + AW'(beat);
    // Word to load into bus_resp on the next edge: line base when leaving RWAIT,
    // the following beat when the current beat is accepted in RDATA.
    assign rd_idx = (state == RDATA) ? wr_idx + AW'(1) : line;

    // Storage has no reset so a reset mid-burst leaves written beats intact.
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_idx] <= bus_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            line        <= '0;
            beat        <= '0;
            cnt         <= '0;
            tag         <= '0;
            bus_reqack  <= 1'b0;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            bus_resptag <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus_reqcyc) begin
                        line       <= bus_req[3 +: AW] & ~AW'(7);
                        tag        <= bus_reqtag;
                        bus_reqack <= 1'b1;
                        state      <= AACK;
                    end
                end
                AACK: begin
                    bus_reqack <= 1'b0;
                    beat       <= '0;
                    cnt        <= CW'(READ_LATENCY - 1);
                    state      <= (tag[11:8] != TYPE_MEMORY) ? DROP :
                                  tag[12] ? RWAIT : WDATA;
                end
                DROP: state <= IDLE;
                WDATA: begin
                    if (bus_reqcyc) begin
                        bus_reqack <= 1'b1;
                        state      <= WACK;
                    end
                end
                WACK: begin
                    bus_reqack <= 1'b0;
                    beat       <= beat + 3'd1;
                    state      <= (beat == 3'd7) ? IDLE : WDATA;
                end
                RWAIT: begin
                    if (cnt == '0) begin
                        bus_respcyc <= 1'b1;
                        bus_resp    <= mem[rd_idx];
                        bus_resptag <= tag;
                        state       <= RDATA;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RDATA: begin
                    if (bus_respack) begin
                        beat <= beat + 3'd1;
                        if (beat == 3'd7) begin
                            bus_respcyc <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            bus_resp <= mem[rd_idx];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder: directed bench for sysbus_mem_responder
module tb_sysbus_mem_responder;
    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bus_reqcyc = 1'b0;
    logic [63:0] bus_req = '0;
    logic [12:0] bus_reqtag = '0;
    logic        bus_respack = 1'b0;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int resp_cnt = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH(64),
        .BUS_TAG_WIDTH(13),
        .MEM_WORDS(4096),
        .READ_LATENCY(L)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus_reqcyc(bus_reqcyc),
        .bus_req(bus_req),
        .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc),
        .bus_resp(bus_resp),
        .bus_resptag(bus_resptag),
        .bus_respack(bus_respack)
    );

    always @(negedge clk) begin
        if (bus_reqack) ack_cnt++;
        if (bus_respcyc) resp_cnt++;
        if (bus_reqack && bus_respcyc) overlap++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        do begin
            tick;
            n++;
        end while (!bus_reqack && n < 20);
        check(name, 64'(bus_reqack), 64'd1);
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [12:0] tag, input logic [63:0] base);
        int a;
        int a0 = ack_cnt;
        bus_reqcyc = 1'b1;
        bus_req    = addr;
        bus_reqtag = tag;
        wait_ack("wr_addr_ack");
        a = cyc;
        for (int i = 0; i < 8; i++) begin
            bus_req = base + 64'(i);
            wait_ack("wr_data_ack");
        end
        check("wr_cycles", 64'(cyc - a), 64'd16);
        bus_reqcyc = 1'b0;
        tick;
        check("wr_ack_pulses", 64'(ack_cnt - a0), 64'd9);
    endtask

    // mode 0: respack held high (also while no beat is valid); mode 1: 1,0,0,1,0,0,...
    task automatic do_read(input logic [63:0] addr, input logic [12:0] tag, input logic [63:0] base,
                           input int mode, input int abort_at);
        int a;
        int k = 0;
        int n = 0;
        int tmo = 0;
        bit first = 1'b1;
        bus_reqcyc  = 1'b1;
        bus_req     = addr;
        bus_reqtag  = tag;
        bus_respack = (mode == 0);
        wait_ack("rd_addr_ack");
        a = cyc;
        bus_reqcyc = 1'b0;
        while (k < 8 && tmo < 100) begin
            tick;
            tmo++;
            if (bus_respcyc) begin
                if (first) begin
                    check("rd_latency", 64'(cyc - a), 64'(L + 1));
                    first = 1'b0;
                end
                check("rd_data", bus_resp, base + 64'(k));
                check("rd_tag", 64'(bus_resptag), 64'(tag));
                if (k == abort_at) return;
                bus_respack = (mode == 0) || (n % 3 == 0);
                n++;
                if (bus_respack) k++;
            end
        end
        check("rd_beats", 64'(k), 64'd8);
        tick;
        check("rd_done", 64'(bus_respcyc), 64'd0);
        bus_respack = 1'b0;
    endtask

    initial begin
        int r0;
        int a0;
        tick;
        tick;
        check("rst_reqack", 64'(bus_reqack), 64'd0);
        check("rst_respcyc", 64'(bus_respcyc), 64'd0);
        check("rst_resp", bus_resp, 64'd0);
        check("rst_resptag", 64'(bus_resptag), 64'd0);
        reset = 1'b0;
        tick;

        do_write(64'h1000, 13'h0100, 64'hA0);
        do_read(64'h1000, 13'h11A5, 64'hA0, 0, 8);
        do_read(64'h1028, 13'h1107, 64'hA0, 0, 8);
        do_read(64'h1000, 13'h1133, 64'hA0, 1, 8);

        r0 = resp_cnt;
        a0 = ack_cnt;
        bus_reqcyc = 1'b1;
        bus_req    = 64'h1000;
        bus_reqtag = 13'h1244;
        wait_ack("drop_addr_ack");
        bus_reqcyc = 1'b0;
        repeat (20) tick;
        check("drop_acks", 64'(ack_cnt - a0), 64'd1);
        check("drop_resp", 64'(resp_cnt - r0), 64'd0);
        do_read(64'h1010, 13'h1155, 64'hA0, 0, 8);

        do_write(64'hFFC0, 13'h0177, 64'hC0);
        check("wrap_lo", dut.mem[4088], 64'hC0);
        check("wrap_hi", dut.mem[4095], 64'hC7);
        do_read(64'h7FC0, 13'h1166, 64'hC0, 0, 8);

        do_read(64'h7FC0, 13'h1199, 64'hC0, 0, 3);
        reset = 1'b1;
        tick;
        check("midrst_reqack", 64'(bus_reqack), 64'd0);
        check("midrst_respcyc", 64'(bus_respcyc), 64'd0);
        check("midrst_resp", bus_resp, 64'd0);
        check("midrst_resptag", 64'(bus_resptag), 64'd0);
        reset = 1'b0;
        bus_respack = 1'b0;
        tick;
        do_read(64'h7FC0, 13'h1188, 64'hC0, 1, 8);

        check("ack_resp_overlap", 64'(overlap), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
